// File: rtl/fc_pkg.sv
// fc_pkg: shared configuration for the argmax classifier slice.
//   NUM_CLASSES : scores per frame
//   SCORE_W     : signed score width (matches dense layer data_out)
//   CLASS_W     : class index width, 2**CLASS_W >= NUM_CLASSES
//   state_t     : collector FSM encoding
package fc_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 12;
  localparam int CLASS_W     = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;
endpackage

// File: rtl/fc_argmax_classifier_if.sv
// fc_argmax_classifier_if: score stream in, result handshake out.
//   valid_in/score_in/frame_start : serial score stream from the dense layer
//   class_out/max_score/valid_out : winning result towards the sink
//   ready_in                      : sink accepts the result
// slave modport is the classifier side, master modport the driver/sink side.
interface fc_argmax_classifier_if
  import fc_pkg::*;
#(
  parameter int SCORE_W = fc_pkg::SCORE_W,
  parameter int CLASS_W = fc_pkg::CLASS_W
);
  logic               valid_in;
  logic [SCORE_W-1:0] score_in;
  logic               frame_start;
  logic [CLASS_W-1:0] class_out;
  logic [SCORE_W-1:0] max_score;
  logic               valid_out;
  logic               ready_in;

  modport slave (
    input  valid_in, score_in, frame_start, ready_in,
    output class_out, max_score, valid_out
  );
  modport master (
    output valid_in, score_in, frame_start, ready_in,
    input  class_out, max_score, valid_out
  );
endinterface

// File: rtl/fc_score_bank.sv
// fc_score_bank: NUM_CLASSES x SCORE_W score store with a registered read port.
//   wr_en/wr_addr/wr_data : write port, one score per accepted beat
//   rd_addr -> rd_data    : read data valid one cycle after rd_addr;
//                           out-of-range addresses read as 0
// Only rd_data is reset; the storage itself is not.
module fc_score_bank
  import fc_pkg::*;
#(
  parameter int N  = fc_pkg::NUM_CLASSES,
  parameter int W  = fc_pkg::SCORE_W,
  parameter int AW = fc_pkg::CLASS_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [N-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rd_data <= '0;
    else if (int'(rd_addr) < N)  rd_data <= mem[rd_addr];
    else                         rd_data <= '0;
  end
endmodule

// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: running argmax over a serial frame of signed scores.
//   clk, rst_n (async, active-low)
//   io.slave   : score stream in, result (class_out/max_score/valid_out) out
//                held until valid_out & ready_in
//   busy       : frame partially collected
//   drop_pulse : one-cycle pulse per score discarded while a result is pending
// Optional build macro FC_ARGMAX_READBACK_EN adds rd_addr/rd_data and a
// score bank holding the scores of the frame being collected.
module fc_argmax_classifier
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = fc_pkg::NUM_CLASSES,
  parameter int SCORE_W     = fc_pkg::SCORE_W,
  parameter int CLASS_W     = fc_pkg::CLASS_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fc_argmax_classifier_if.slave  io,
`ifdef FC_ARGMAX_READBACK_EN
  input  logic [CLASS_W-1:0]     rd_addr,
  output logic [SCORE_W-1:0]     rd_data,
`endif
  output logic                   busy,
  output logic                   drop_pulse
);
  state_t             state, state_nxt;
  logic [CLASS_W-1:0] cnt, cur_idx;
  logic [SCORE_W-1:0] cur_max;
  logic               hs, accept, restart, done, gt;

  // A beat in HOLD is only taken on the handshake cycle; cnt is 0 there,
  // so it always starts a new frame regardless of frame_start.
  always_comb begin
    hs      = (state == HOLD) && io.ready_in;
    accept  = io.valid_in && ((state == COLLECT) || hs);
    restart = accept && ((cnt == '0) || io.frame_start);
    done    = accept && !restart && (cnt == CLASS_W'(NUM_CLASSES-1));
    gt      = $signed(io.score_in) > $signed(cur_max);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (done) state_nxt = HOLD;
      HOLD:    if (hs)   state_nxt = COLLECT;
      default:           state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      cur_idx      <= '0;
      cur_max      <= '0;
      io.class_out <= '0;
      io.max_score <= '0;
      drop_pulse   <= 1'b0;
    end else begin
      drop_pulse <= (state == HOLD) && io.valid_in && !io.ready_in;
      if (restart) begin
        cur_max <= io.score_in;
        cur_idx <= '0;
        cnt     <= CLASS_W'(1);
      end else if (accept) begin
        // strict compare: ties keep the earlier (lower) class
        if (gt) begin
          cur_max <= io.score_in;
          cur_idx <= cnt;
        end
        cnt <= done ? '0 : cnt + CLASS_W'(1);
      end
      if (done) begin
        io.class_out <= gt ? cnt : cur_idx;
        io.max_score <= gt ? io.score_in : cur_max;
      end
    end
  end

  assign io.valid_out = (state == HOLD);
  assign busy         = (state == COLLECT) && (cnt != '0);

`ifdef FC_ARGMAX_READBACK_EN
  fc_score_bank #(.N(NUM_CLASSES), .W(SCORE_W), .AW(CLASS_W)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (restart ? '0 : cnt),
    .wr_data (io.score_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`endif
endmodule

// File: tb/tb_fc_argmax_classifier.sv
// tb_fc_argmax_classifier: directed checks of the argmax classifier.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fc_argmax_classifier;
  import fc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, drop_pulse;
`ifdef FC_ARGMAX_READBACK_EN
  logic [CLASS_W-1:0] rd_addr;
  logic [SCORE_W-1:0] rd_data;
`endif
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fc_argmax_classifier_if #(.SCORE_W(SCORE_W), .CLASS_W(CLASS_W)) bus ();

  fc_argmax_classifier #(
    .NUM_CLASSES(NUM_CLASSES), .SCORE_W(SCORE_W), .CLASS_W(CLASS_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (bus.slave),
`ifdef FC_ARGMAX_READBACK_EN
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
`endif
    .busy       (busy),
    .drop_pulse (drop_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int score, input logic fs);
    bus.valid_in    = 1'b1;
    bus.score_in    = SCORE_W'(score);
    bus.frame_start = fs;
    tick();
    bus.valid_in    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int cls, input logic [SCORE_W-1:0] sc);
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    chk({tag, "_class"}, 32'(bus.class_out), 32'(cls));
    chk({tag, "_score"}, 32'(bus.max_score), 32'(sc));
  endtask

  int f1[10] = '{-5, 1, 2, 3, 4, 5, 6, 7, 8, 100};
  int f2[10] = '{-200, -150, -100, -1, -90, -80, -50, -1, -30, -20};
  int f3[10] = '{3, 7, 2, 9, -4, 9, 0, 1, 5, 8};

  initial begin
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.score_in = '0; bus.frame_start = 1'b0; bus.ready_in = 1'b0;
`ifdef FC_ARGMAX_READBACK_EN
    rd_addr = '0;
`endif
    #12;
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_class", 32'(bus.class_out), 0);
    chk("rst_score", 32'(bus.max_score), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_drop",  32'(drop_pulse), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // monotonic frame, sink always ready
    bus.ready_in = 1'b1;
    send(f1[0], 1'b0);
    chk("f1_busy", 32'(busy), 1);
    chk("f1_novalid", 32'(bus.valid_out), 0);
    for (int i = 1; i < 10; i++) send(f1[i], 1'b0);
    chk_res("f1", 9, 12'h064);
    chk("f1_busy_done", 32'(busy), 0);
    tick();
    chk("f1_valid_drop", 32'(bus.valid_out), 0);
`ifdef FC_ARGMAX_READBACK_EN
    rd_addr = 4'd9;
    tick();
    chk("rb_addr9", 32'(rd_data), 32'h064);
    rd_addr = 4'd12;
    tick();
    chk("rb_addr12", 32'(rd_data), 0);
`endif

    // all negative, tie at -1 on classes 3 and 7
    bus.ready_in = 1'b0;
    for (int i = 0; i < 10; i++) send(f2[i], 1'b0);
    chk_res("f2", 3, 12'hFFF);
    bus.ready_in = 1'b1;
    tick();
    chk("f2_ack", 32'(bus.valid_out), 0);
    bus.ready_in = 1'b0;

    // gapped input, then stalled sink with extra beats
    for (int i = 0; i < 10; i++) begin
      send(f3[i], 1'b0);
      if (i < 9) begin
        tick(); tick();
        chk($sformatf("f3_gap_busy%0d", i), 32'(busy), 1);
      end
    end
    chk_res("f3", 3, 12'h009);
    tick();
    send(55, 1'b0);
    chk("f3_drop1", 32'(drop_pulse), 1);
    tick();
    chk("f3_drop1_end", 32'(drop_pulse), 0);
    send(55, 1'b1);
    chk("f3_drop2", 32'(drop_pulse), 1);
    tick();
    chk("f3_drop2_end", 32'(drop_pulse), 0);
    chk_res("f3_hold", 3, 12'h009);
    bus.ready_in = 1'b1;
    tick();
    chk("f3_ack", 32'(bus.valid_out), 0);
    chk("f3_ack_busy", 32'(busy), 0);
    bus.ready_in = 1'b0;

    // partial frame aborted by frame_start
    send(120, 1'b0); send(110, 1'b0); send(100, 1'b0); send(90, 1'b0);
    send(50, 1'b1);
    for (int i = 0; i < 9; i++) send(49 - i, 1'b0);
    chk_res("f4", 0, 12'h032);

    // async reset while holding
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(bus.valid_out), 0);
    chk("rst_hold_class", 32'(bus.class_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) send(i + 1, 1'b0);
    chk_res("f5", 9, 12'h00A);

    // handshake cycle carries class 0 of the next frame
    bus.ready_in = 1'b1;
    send(77, 1'b0);
    chk("f6_ack", 32'(bus.valid_out), 0);
    chk("f6_busy", 32'(busy), 1);
    bus.ready_in = 1'b0;
    for (int i = 0; i < 9; i++) send(i, 1'b0);
    chk_res("f6", 0, 12'h04D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
- Consumer of the dense layer's serial score stream. Receives NUM_CLASSES signed scores, one per valid_in beat, in class order 0..NUM_CLASSES-1.
- Tracks the running maximum and reports the winning class index with its score.
- Holds the result under a valid/ready handshake towards the result sink (UART/LED/host register).
- Final stage of the MNIST CNN pipeline.

Parameters:
- NUM_CLASSES, 10, scores per frame (2..16).
- SCORE_W, 12, signed score width; matches the dense layer's data_out.
- CLASS_W, 4, index width; must satisfy 2^CLASS_W >= NUM_CLASSES.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  score_in valid this cycle
- score_in  in  SCORE_W  signed class score
- frame_start  in  1  resync; the beat carrying it is class 0
- class_out  out  CLASS_W  winning class index
- max_score  out  SCORE_W  winning score (signed)
- valid_out  out  1  result valid; held until accepted
- ready_in  in  1  sink accepts result
- busy  out  1  frame partially collected (score count != 0)
- drop_pulse  out  1  one-cycle pulse: score discarded while result pending

Behaviour:
- Reset values:
  - class_out=0, max_score=0, valid_out=0, busy=0, drop_pulse=0.
  - Internal: cnt=0, state=COLLECT.
- States: COLLECT and HOLD.
- COLLECT, on each valid_in:
  - If cnt==0 or frame_start=1: load max=score_in, idx=0, cnt=1.
  - Otherwise, if score_in > max (signed, strict): max=score_in, idx=cnt. Then cnt++.
  - Strict compare means ties keep the lowest index.
  - When the beat that brings cnt to NUM_CLASSES is accepted (cnt==NUM_CLASSES-1 with valid_in):
    - Next cycle: class_out/max_score hold the final result and valid_out=1.
    - cnt returns to 0; state moves to HOLD.
    - Latency from last score to valid_out is 1 cycle.
- HOLD:
  - valid_out stays 1; class_out and max_score stay stable until valid_out&ready_in.
  - On handshake: valid_out=0 next cycle, state=COLLECT.
  - valid_in on the handshake cycle is accepted as class 0 of the next frame, regardless of frame_start.
  - valid_in in HOLD without handshake is discarded; drop_pulse=1 the next cycle.
- frame_start:
  - In COLLECT, when asserted with valid_in, aborts any partial frame and restarts at class 0.
  - Ignored when valid_in=0.
  - In HOLD, treated like any other beat (accepted only on the handshake cycle).
- busy=1 whenever state==COLLECT and cnt!=0.
- valid_in=0 gaps inside a frame are allowed and leave state unchanged.
- Asynchronous reset mid-frame or in HOLD: all state cleared, the pending result is lost, valid_out drops immediately.
- Comparison is full SCORE_W signed; no saturation or truncation.

Optional Feature:
- Macro FC_ARGMAX_READBACK_EN.
- When defined:
  - Adds an NUM_CLASSES x SCORE_W score bank.
  - Adds ports rd_addr (in, CLASS_W) and rd_data (out, SCORE_W).
  - Each accepted score in COLLECT is written at address cnt.
  - rd_data is registered: the bank[rd_addr] value appears 1 cycle after rd_addr.
  - rd_addr >= NUM_CLASSES returns 0. Reset clears rd_data to 0; bank contents are not reset.
- When undefined: ports and bank are absent; behaviour is otherwise identical.

Decomposition:
- Package fc_pkg holds:
  - localparams NUM_CLASSES=10, SCORE_W=12, CLASS_W=4.
  - The state encoding (COLLECT=1'b0, HOLD=1'b1).
- One natural sub-module, fc_score_bank: the readback RAM with its registered read port. It is instantiated only under FC_ARGMAX_READBACK_EN.

Test Plan:
- Monotonic frame, scores -5,1,2,3,4,5,6,7,8,100 on consecutive cycles, ready_in=1 -> valid_out 1 cycle after the last beat, class_out=9, max_score=100, valid_out low the following cycle.
- All negative scores -200..-20, class 3 = -1, ties at -1 on classes 3 and 7 -> class_out=3, max_score=-1 (0xFFF).
- Gapped input (valid_in every 3rd cycle), ready_in=0 for 5 cycles after valid_out, extra valid_in in HOLD -> result stable, drop_pulse once per dropped beat; ready_in=1 -> next cycle valid_out=0.
- Partial frame of 4 scores, then frame_start with score 50 followed by 9 scores <50 -> class_out=0, max_score=50; the aborted scores have no effect.
- rst_n low during HOLD -> valid_out=0, class_out=0 immediately; next frame is reported correctly. Handshake cycle with simultaneous valid_in=77 -> 77 counted as class 0 of the next frame.
- Under FC_ARGMAX_READBACK_EN: after the first frame, rd_addr=9 -> rd_data=100 one cycle later; rd_addr=12 -> rd_data=0.
